// File: rtl/id_ex_register_if.sv
// Purpose : bundles the hazard controls (stall/flush), the decode-stage fields (id_*)
//           and the execute-stage registered fields (ex_*) of the ID/EX pipeline register.
// Ports   : master = decode/hazard side (drives id_*, stall, flush; observes ex_*),
//           slave  = the pipeline register itself (consumes id_*, drives ex_* and bubble_count).
interface id_ex_register_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // hazard controls
    logic              stall;
    logic              flush;

    // decode stage
    logic              id_valid;
    logic [DATA_W-1:0] id_pc_plus4;
    logic [DATA_W-1:0] id_read_data1;
    logic [DATA_W-1:0] id_read_data2;
    logic [DATA_W-1:0] id_imm;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [5:0]        id_func;
    logic [1:0]        id_alu_op;
    logic              id_reg_dst;
    logic              id_alu_src;
    logic              id_branch;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_mem_to_reg;
    logic              id_reg_write;

    // execute stage
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc_plus4;
    logic [DATA_W-1:0] ex_read_data1;
    logic [DATA_W-1:0] ex_read_data2;
    logic [DATA_W-1:0] ex_imm;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic [5:0]        ex_func;
    logic [1:0]        ex_alu_op;
    logic              ex_reg_dst;
    logic              ex_alu_src;
    logic              ex_branch;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic              ex_reg_write;

    // statistics
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output stall, flush,
        output id_valid, id_pc_plus4, id_read_data1, id_read_data2, id_imm,
        output id_rs, id_rt, id_rd, id_func, id_alu_op,
        output id_reg_dst, id_alu_src, id_branch, id_mem_read, id_mem_write,
        output id_mem_to_reg, id_reg_write,
        input  ex_valid, ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm,
        input  ex_rs, ex_rt, ex_rd, ex_func, ex_alu_op,
        input  ex_reg_dst, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write,
        input  ex_mem_to_reg, ex_reg_write,
        input  bubble_count
    );

    modport slave (
        input  stall, flush,
        input  id_valid, id_pc_plus4, id_read_data1, id_read_data2, id_imm,
        input  id_rs, id_rt, id_rd, id_func, id_alu_op,
        input  id_reg_dst, id_alu_src, id_branch, id_mem_read, id_mem_write,
        input  id_mem_to_reg, id_reg_write,
        output ex_valid, ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm,
        output ex_rs, ex_rt, ex_rd, ex_func, ex_alu_op,
        output ex_reg_dst, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write,
        output ex_mem_to_reg, ex_reg_write,
        output bubble_count
    );
endinterface

// File: rtl/id_ex_register.sv
// Purpose : ID/EX pipeline register with flush/stall hazard control and a saturating
//           bubble counter. Ports: clk, reset (async, active-high), bus (slave modport).
// Latency : one clock edge from id_* to ex_*; all outputs come straight from flops.
// Backpres: stall holds every ex_* field and the counter; flush overrides stall and
//           inserts an all-zero bubble.
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            reset,
    id_ex_register_if.slave bus
);

    localparam logic [DATA_W-1:0] DATA_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ex_valid      <= 1'b0;
            bus.ex_pc_plus4   <= DATA_ZERO;
            bus.ex_read_data1 <= DATA_ZERO;
            bus.ex_read_data2 <= DATA_ZERO;
            bus.ex_imm        <= DATA_ZERO;
            bus.ex_rs         <= 5'd0;
            bus.ex_rt         <= 5'd0;
            bus.ex_rd         <= 5'd0;
            bus.ex_func       <= 6'd0;
            bus.ex_alu_op     <= 2'd0;
            bus.ex_reg_dst    <= 1'b0;
            bus.ex_alu_src    <= 1'b0;
            bus.ex_branch     <= 1'b0;
            bus.ex_mem_read   <= 1'b0;
            bus.ex_mem_write  <= 1'b0;
            bus.ex_mem_to_reg <= 1'b0;
            bus.ex_reg_write  <= 1'b0;
            bus.bubble_count  <= '0;
        end else if (bus.flush) begin
            // Branch taken: the whole stage becomes a zero bubble, whatever stall says.
            bus.ex_valid      <= 1'b0;
            bus.ex_pc_plus4   <= DATA_ZERO;
            bus.ex_read_data1 <= DATA_ZERO;
            bus.ex_read_data2 <= DATA_ZERO;
            bus.ex_imm        <= DATA_ZERO;
            bus.ex_rs         <= 5'd0;
            bus.ex_rt         <= 5'd0;
            bus.ex_rd         <= 5'd0;
            bus.ex_func       <= 6'd0;
            bus.ex_alu_op     <= 2'd0;
            bus.ex_reg_dst    <= 1'b0;
            bus.ex_alu_src    <= 1'b0;
            bus.ex_branch     <= 1'b0;
            bus.ex_mem_read   <= 1'b0;
            bus.ex_mem_write  <= 1'b0;
            bus.ex_mem_to_reg <= 1'b0;
            bus.ex_reg_write  <= 1'b0;
            if (bus.bubble_count != CNT_MAX)
                bus.bubble_count <= bus.bubble_count + CNT_ONE;
        end else if (!bus.stall) begin
            // Data fields always load; control bits are gated by id_valid so an
            // invalid slot can never write memory or the register file downstream.
            bus.ex_pc_plus4   <= bus.id_pc_plus4;
            bus.ex_read_data1 <= bus.id_read_data1;
            bus.ex_read_data2 <= bus.id_read_data2;
            bus.ex_imm        <= bus.id_imm;
            bus.ex_rs         <= bus.id_rs;
            bus.ex_rt         <= bus.id_rt;
            bus.ex_rd         <= bus.id_rd;
            bus.ex_func       <= bus.id_func;
            bus.ex_valid      <= bus.id_valid;
            bus.ex_alu_op     <= bus.id_valid ? bus.id_alu_op : 2'd0;
            bus.ex_reg_dst    <= bus.id_valid & bus.id_reg_dst;
            bus.ex_alu_src    <= bus.id_valid & bus.id_alu_src;
            bus.ex_branch     <= bus.id_valid & bus.id_branch;
            bus.ex_mem_read   <= bus.id_valid & bus.id_mem_read;
            bus.ex_mem_write  <= bus.id_valid & bus.id_mem_write;
            bus.ex_mem_to_reg <= bus.id_valid & bus.id_mem_to_reg;
            bus.ex_reg_write  <= bus.id_valid & bus.id_reg_write;
            if (!bus.id_valid && (bus.bubble_count != CNT_MAX))
                bus.bubble_count <= bus.bubble_count + CNT_ONE;
        end
        // stall without flush: every flop keeps its value
    end

endmodule

// File: tb/tb_id_ex_register.sv
module tb_id_ex_register;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [5:0]        func;
        logic [1:0]        alu_op;
        logic              reg_dst;
        logic              alu_src;
        logic              branch;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
    } stage_t;

    logic   clk = 1'b0;
    logic   reset;
    logic   stall;
    logic   flush;
    stage_t din;

    // reference state
    stage_t exp_s;
    int     exp_cnt;

    int vectors    = 0;
    int miscompares = 0;

    id_ex_register_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    id_ex_register #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.stall         = stall;
    assign bus.flush         = flush;
    assign bus.id_valid      = din.valid;
    assign bus.id_pc_plus4   = din.pc_plus4;
    assign bus.id_read_data1 = din.rd1;
    assign bus.id_read_data2 = din.rd2;
    assign bus.id_imm        = din.imm;
    assign bus.id_rs         = din.rs;
    assign bus.id_rt         = din.rt;
    assign bus.id_rd         = din.rd;
    assign bus.id_func       = din.func;
    assign bus.id_alu_op     = din.alu_op;
    assign bus.id_reg_dst    = din.reg_dst;
    assign bus.id_alu_src    = din.alu_src;
    assign bus.id_branch     = din.branch;
    assign bus.id_mem_read   = din.mem_read;
    assign bus.id_mem_write  = din.mem_write;
    assign bus.id_mem_to_reg = din.mem_to_reg;
    assign bus.id_reg_write  = din.reg_write;

    function automatic stage_t observed();
        stage_t o;
        o.valid      = bus.ex_valid;
        o.pc_plus4   = bus.ex_pc_plus4;
        o.rd1        = bus.ex_read_data1;
        o.rd2        = bus.ex_read_data2;
        o.imm        = bus.ex_imm;
        o.rs         = bus.ex_rs;
        o.rt         = bus.ex_rt;
        o.rd         = bus.ex_rd;
        o.func       = bus.ex_func;
        o.alu_op     = bus.ex_alu_op;
        o.reg_dst    = bus.ex_reg_dst;
        o.alu_src    = bus.ex_alu_src;
        o.branch     = bus.ex_branch;
        o.mem_read   = bus.ex_mem_read;
        o.mem_write  = bus.ex_mem_write;
        o.mem_to_reg = bus.ex_mem_to_reg;
        o.reg_write  = bus.ex_reg_write;
        return o;
    endfunction

    function automatic stage_t rand_stage();
        stage_t s;
        s.valid      = ($urandom_range(0, 3) != 0);
        s.pc_plus4   = $urandom;
        s.rd1        = $urandom;
        s.rd2        = $urandom;
        s.imm        = $urandom;
        s.rs         = 5'($urandom);
        s.rt         = 5'($urandom);
        s.rd         = 5'($urandom);
        s.func       = 6'($urandom);
        s.alu_op     = 2'($urandom);
        s.reg_dst    = 1'($urandom);
        s.alu_src    = 1'($urandom);
        s.branch     = 1'($urandom);
        s.mem_read   = 1'($urandom);
        s.mem_write  = 1'($urandom);
        s.mem_to_reg = 1'($urandom);
        s.reg_write  = 1'($urandom);
        return s;
    endfunction

    function automatic int bump(input int c);
        return (c < CNT_SAT) ? c + 1 : c;
    endfunction

    // Reference behaviour of one rising edge, taken from the stage rules:
    // reset -> all zero; flush -> zero bubble, count+1; stall -> hold;
    // load -> copy, with the control group dropped and a bubble counted if invalid.
    task automatic model_edge();
        stage_t nxt;
        if (reset) begin
            exp_s   = '0;
            exp_cnt = 0;
        end else if (flush) begin
            exp_s   = '0;
            exp_cnt = bump(exp_cnt);
        end else if (!stall) begin
            nxt = din;
            if (!din.valid) begin
                nxt.alu_op     = 2'b00;
                nxt.reg_dst    = 1'b0;
                nxt.alu_src    = 1'b0;
                nxt.branch     = 1'b0;
                nxt.mem_read   = 1'b0;
                nxt.mem_write  = 1'b0;
                nxt.mem_to_reg = 1'b0;
                nxt.reg_write  = 1'b0;
                exp_cnt        = bump(exp_cnt);
            end
            exp_s = nxt;
        end
    endtask

    task automatic check_state(input string tag);
        stage_t o;
        logic [CNT_W-1:0] ec;
        o  = observed();
        ec = CNT_W'(exp_cnt);
        vectors++;
        assert (o === exp_s) else begin
            miscompares++;
            $error("FAIL %s stage: observed %h expected %h", tag, o, exp_s);
        end
        vectors++;
        assert (bus.bubble_count === ec) else begin
            miscompares++;
            $error("FAIL %s bubble_count: observed %0d expected %0d", tag, bus.bubble_count, ec);
        end
    endtask

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One rising edge: update the model from the values present at the edge,
    // then compare 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_state(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        exp_s   = '0;
        exp_cnt = 0;
        check_state("reset_async");
        tick("reset_held");
        #2 reset = 1'b0;
    endtask

    int cnt_before;

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        din   = '0;
        exp_s   = '0;
        exp_cnt = 0;

        // reset state before any clock edge
        #1;
        check_state("por");

        // clock edges during reset leave everything at zero, whatever the inputs
        for (int i = 0; i < 4; i++) begin
            din   = rand_stage();
            din.valid = 1'b1;
            stall = 1'($urandom);
            flush = 1'($urandom);
            tick("reset_edges");
        end
        #2 reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;

        // first edge after release performs a normal load (R-type SUB)
        din           = rand_stage();
        din.valid     = 1'b1;
        din.alu_op    = 2'b10;
        din.func      = 6'b100010;
        din.rd1       = 32'h0000_0005;
        din.reg_write = 1'b1;
        tick("load_rtype");
        check_val("load_alu_op", 64'(bus.ex_alu_op), 64'h2);
        check_val("load_func", 64'(bus.ex_func), 64'h22);
        check_val("load_rd1", 64'(bus.ex_read_data1), 64'h5);
        check_val("load_reg_write", 64'(bus.ex_reg_write), 64'h1);
        check_val("load_count", 64'(bus.bubble_count), 64'h0);

        // stall holds A for three edges while B is presented, then B loads
        din       = rand_stage();
        din.valid = 1'b1;
        tick("stall_load_a");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din       = rand_stage();
            din.valid = 1'b1;
            tick("stall_hold");
        end
        stall = 1'b0;
        tick("stall_release_b");

        // flush beats stall while a valid ADD sits in the stage
        din           = rand_stage();
        din.valid     = 1'b1;
        din.alu_op    = 2'b10;
        din.func      = 6'b100000;
        din.reg_write = 1'b1;
        tick("add_load");
        cnt_before = int'(bus.bubble_count);
        stall = 1'b1;
        flush = 1'b1;
        tick("flush_over_stall");
        check_val("flush_valid", 64'(bus.ex_valid), 64'h0);
        check_val("flush_reg_write", 64'(bus.ex_reg_write), 64'h0);
        check_val("flush_mem_write", 64'(bus.ex_mem_write), 64'h0);
        check_val("flush_func", 64'(bus.ex_func), 64'h0);
        check_val("flush_count", 64'(bus.bubble_count), 64'(bump(cnt_before)));
        stall = 1'b0;
        flush = 1'b0;

        // invalid instruction never reaches memory or register file
        din           = rand_stage();
        din.valid     = 1'b0;
        din.mem_write = 1'b1;
        din.reg_write = 1'b1;
        cnt_before    = int'(bus.bubble_count);
        tick("invalid_load");
        check_val("invalid_mem_write", 64'(bus.ex_mem_write), 64'h0);
        check_val("invalid_reg_write", 64'(bus.ex_reg_write), 64'h0);
        check_val("invalid_count", 64'(bus.bubble_count), 64'(bump(cnt_before)));

        // saturation: 20 flushes pin the 4-bit counter at 4'hF
        flush = 1'b1;
        for (int i = 0; i < 20; i++) tick("saturate");
        check_val("saturated", 64'(bus.bubble_count), 64'hF);
        flush = 1'b0;
        din   = rand_stage();
        din.valid = 1'b0;
        tick("saturated_invalid");
        check_val("still_saturated", 64'(bus.bubble_count), 64'hF);

        // async reset mid-cycle with count=7 and a register-writing instruction held
        do_reset();
        flush = 1'b1;
        for (int i = 0; i < 7; i++) tick("count_to_7");
        flush = 1'b0;
        din           = rand_stage();
        din.valid     = 1'b1;
        din.reg_write = 1'b1;
        tick("pre_reset_load");
        check_val("pre_reset_count", 64'(bus.bubble_count), 64'h7);
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        exp_s   = '0;
        exp_cnt = 0;
        check_state("midcycle_reset");
        #2 reset = 1'b0;
        stall = 1'b0;
        din       = rand_stage();
        din.valid = 1'b1;
        tick("post_reset_load");

        // randomized traffic, with stall/flush glitches between edges
        for (int i = 0; i < 400; i++) begin
            din   = rand_stage();
            stall = 1'($urandom);
            flush = 1'($urandom);
            #2;
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            if ((i % 97) == 96) begin
                do_reset();
            end else begin
                tick("random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, width of PC, register-data and immediate fields.
REQ-002 SHALL provide parameter CNT_W, default 16, width of the bubble-count statistic.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold all stage contents (load-use hazard).
REQ-006 SHALL have port flush  input  1  replace next stage contents with a bubble (branch taken).
REQ-007 SHALL have port id_valid  input  1  decode stage holds a real instruction.
REQ-008 SHALL have ports id_pc_plus4, id_read_data1, id_read_data2, id_imm  input  DATA_W each  decode-stage data fields.
REQ-009 SHALL have ports id_rs, id_rt, id_rd  input  5 each  register specifiers.
REQ-010 SHALL have port id_func  input  6  instruction function field, forwarded to ALU control.
REQ-011 SHALL have port id_alu_op  input  2  ALU operation class, forwarded to ALU control.
REQ-012 SHALL have ports id_reg_dst, id_alu_src, id_branch, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write  input  1 each  control bits.
REQ-013 SHALL have an ex_-prefixed registered output of identical width for every id_ input in REQ-007..REQ-012.
REQ-014 SHALL have port bubble_count  output  CNT_W  number of bubbles inserted since reset, saturating.

Function
REQ-015 SHALL implement one register stage; latency from id_ input to ex_ output is exactly one clock edge.
REQ-016 SHALL define control group = ex_valid, ex_alu_op, ex_reg_dst, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write.
REQ-017 SHALL, each rising edge, apply exactly one action by priority: flush > stall > load.
REQ-018 Load (flush=0, stall=0): every ex_ output SHALL take its id_ counterpart.
REQ-019 Stall (flush=0, stall=1): every ex_ output SHALL hold its value; bubble_count SHALL hold.
REQ-020 Flush (flush=1, stall don't-care): control group SHALL be cleared to 0; ex_func, ex_rs, ex_rt, ex_rd and all DATA_W fields SHALL be cleared to 0.
REQ-021 Load with id_valid=0 SHALL clear the control group to 0 (bubble) while still loading data fields, so an invalid instruction never asserts ex_mem_write or ex_reg_write.
REQ-022 bubble_count SHALL increment by 1 on every edge where flush=1, or where a load occurs with id_valid=0 (stall edges never count).
REQ-023 bubble_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 ex_alu_op=2'b10 with ex_func passed unmodified SHALL be the only R-type encoding; the block SHALL NOT alter alu_op or func values.
REQ-025 Outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-026 stall and flush SHALL be sampled only at the rising edge; mid-cycle glitches SHALL have no effect.

Reset
REQ-027 Asserting reset SHALL immediately, without a clock edge, clear every ex_ output and bubble_count to 0.
REQ-028 While reset is high, clock edges SHALL leave all outputs at 0 regardless of stall, flush or id_ inputs.
REQ-029 After reset deasserts, the first rising edge SHALL perform a normal priority action (REQ-017).
REQ-030 Reset asserted during a stall SHALL discard the held instruction; no state survives reset.

Verification
REQ-031 Load: id_valid=1, id_alu_op=2'b10, id_func=6'b100010, id_read_data1=32'h0000_0005, id_reg_write=1 -> one edge later ex_alu_op=2'b10, ex_func=6'b100010, ex_read_data1=5, ex_reg_write=1, bubble_count unchanged.
REQ-032 Stall: load instruction A, then hold stall=1 for 3 edges while id_ inputs change to B -> ex_ outputs remain A all 3 cycles; stall=0 -> B appears next edge.
REQ-033 Flush priority: stall=1 and flush=1 on same edge with ex_ holding a valid ADD -> ex_valid=0, ex_reg_write=0, ex_mem_write=0, ex_func=0, bubble_count +1.
REQ-034 Invalid load: id_valid=0, id_mem_write=1, id_reg_write=1 -> ex_mem_write=0, ex_reg_write=0, bubble_count +1.
REQ-035 Saturation: CNT_W=4, 20 consecutive flush edges -> bubble_count reaches 4'hF and stays 4'hF.
REQ-036 Async reset: assert reset mid-cycle while ex_reg_write=1 and bubble_count=7 -> all outputs 0 before the next clock edge; first edge after release loads id_ inputs.
